// File: rtl/usb_buffer_pkg.sv
// Shared constants, state encoding and size decoding for the USB/AHB buffer arbiter.
package usb_buffer_pkg;

  localparam int unsigned BUF_DEPTH = 64;
  localparam int unsigned PTR_W     = 6;
  localparam int unsigned OCC_W     = 7;
  localparam int unsigned LEN_W     = 3;
  localparam int unsigned CNT_W     = 2;

  localparam logic [1:0] SIZE_1B      = 2'b00;
  localparam logic [1:0] SIZE_2B      = 2'b01;
  localparam logic [1:0] SIZE_4B      = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_AHB_XFER = 3'd1,
    ST_USB_XFER = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_ERR      = 3'd4
  } state_e;

  // Byte length of an AHB transfer; zero for the illegal encoding.
  function automatic logic [LEN_W-1:0] size_len(input logic [1:0] size);
    case (size)
      SIZE_1B: size_len = LEN_W'(1);
      SIZE_2B: size_len = LEN_W'(2);
      SIZE_4B: size_len = LEN_W'(4);
      default: size_len = LEN_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/buffer_pointer_tracker.sv
// Read/write pointers (modulo 64) and byte occupancy of the shared buffer.
module buffer_pointer_tracker
  import usb_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_wr,
  input  logic             inc_rd,
  input  logic             clear,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [OCC_W-1:0] occupancy
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (inc_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (inc_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      occupancy <= occupancy + OCC_W'(inc_wr) - OCC_W'(inc_rd);
    end
  end

endmodule

// File: rtl/buffer_arbiter.sv
// Arbitrates AHB multi-byte and USB single-byte accesses to a 64-byte single-port buffer.
// Optional BUFFER_ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous requests.
module buffer_arbiter
  import usb_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ahbReq,
  input  logic             ahbWrite,
  input  logic [1:0]       dataSize,
  input  logic             usbReq,
  input  logic             usbWrite,
  input  logic             flush,
  output logic             bufWe,
  output logic             bufRe,
  output logic [PTR_W-1:0] wrPtr,
  output logic [PTR_W-1:0] rdPtr,
  output logic             ahbGrant,
  output logic             usbGrant,
  output logic             ahbDone,
  output logic             usbDone,
  output logic [OCC_W-1:0] occupancy,
  output logic             bufferReserved,
  output logic             sizeError
);

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             xfer_write, write_next;
  logic             we_next, re_next;
  logic             ahb_grant_next, usb_grant_next;
  logic             ahb_done_next, usb_done_next;
  logic             err_next, reserved_next;
  logic             clear_c, pick_usb_c;
  logic             ahb_ok_c, usb_ok_c;
  logic [LEN_W-1:0] ahb_len_c;
  logic [OCC_W-1:0] occ_next_c;

  buffer_pointer_tracker u_tracker (
    .clk       (clk),
    .rst       (rst),
    .inc_wr    (bufWe),
    .inc_rd    (bufRe),
    .clear     (clear_c),
    .wr_ptr    (wrPtr),
    .rd_ptr    (rdPtr),
    .occupancy (occupancy)
  );

  // Legality of each side's pending request against the current fill level.
  assign ahb_len_c = size_len(dataSize);
  assign ahb_ok_c  = (dataSize != SIZE_ILLEGAL) &&
                     (ahbWrite ? (({1'b0, occupancy} + 8'(ahb_len_c)) <= 8'(BUF_DEPTH))
                               : (OCC_W'(ahb_len_c) <= occupancy));
  assign usb_ok_c  = usbWrite ? (occupancy < OCC_W'(BUF_DEPTH)) : (occupancy != '0);

`ifdef BUFFER_ARB_ROUND_ROBIN_EN
  logic last_usb;

  // Remembers which side was last granted; starts as USB so AHB wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_usb <= 1'b1;
    end else if (state == ST_IDLE && state_next == ST_USB_XFER) begin
      last_usb <= 1'b1;
    end else if (state == ST_IDLE && state_next == ST_AHB_XFER) begin
      last_usb <= 1'b0;
    end
  end

  assign pick_usb_c = usbReq && (!ahbReq || !last_usb);
`else
  assign pick_usb_c = usbReq;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      xfer_write <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      xfer_write <= write_next;
    end
  end

  // Next state plus the output values that will be visible during that state.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    write_next     = xfer_write;
    we_next        = 1'b0;
    re_next        = 1'b0;
    ahb_grant_next = 1'b0;
    usb_grant_next = 1'b0;
    ahb_done_next  = 1'b0;
    usb_done_next  = 1'b0;
    err_next       = 1'b0;
    clear_c        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flush) begin
          state_next = ST_CLEAR;
          clear_c    = 1'b1;
        end else if (pick_usb_c) begin
          if (usb_ok_c) begin
            state_next     = ST_USB_XFER;
            cnt_next       = '0;
            write_next     = usbWrite;
            we_next        = usbWrite;
            re_next        = !usbWrite;
            usb_grant_next = 1'b1;
            usb_done_next  = 1'b1;
          end else begin
            state_next    = ST_ERR;
            err_next      = 1'b1;
            usb_done_next = 1'b1;
          end
        end else if (ahbReq) begin
          if (ahb_ok_c) begin
            state_next     = ST_AHB_XFER;
            cnt_next       = CNT_W'(ahb_len_c - LEN_W'(1));
            write_next     = ahbWrite;
            we_next        = ahbWrite;
            re_next        = !ahbWrite;
            ahb_grant_next = 1'b1;
            ahb_done_next  = (ahb_len_c == LEN_W'(1));
          end else begin
            state_next    = ST_ERR;
            err_next      = 1'b1;
            ahb_done_next = 1'b1;
          end
        end
      end
      ST_AHB_XFER, ST_USB_XFER: begin
        if (cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
          we_next  = xfer_write;
          re_next  = !xfer_write;
          if (state == ST_AHB_XFER) begin
            ahb_grant_next = 1'b1;
            ahb_done_next  = (cnt == CNT_W'(1));
          end else begin
            usb_grant_next = 1'b1;
            usb_done_next  = (cnt == CNT_W'(1));
          end
        end
      end
      ST_CLEAR, ST_ERR: state_next = ST_IDLE;
      default:          state_next = ST_IDLE;
    endcase
  end

  // Fill level after this edge, so bufferReserved tracks occupancy without lag.
  assign occ_next_c    = clear_c ? '0 : (occupancy + OCC_W'(bufWe) - OCC_W'(bufRe));
  assign reserved_next = (state_next == ST_AHB_XFER) || (occ_next_c != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      bufWe          <= 1'b0;
      bufRe          <= 1'b0;
      ahbGrant       <= 1'b0;
      usbGrant       <= 1'b0;
      ahbDone        <= 1'b0;
      usbDone        <= 1'b0;
      sizeError      <= 1'b0;
      bufferReserved <= 1'b0;
    end else begin
      bufWe          <= we_next;
      bufRe          <= re_next;
      ahbGrant       <= ahb_grant_next;
      usbGrant       <= usb_grant_next;
      ahbDone        <= ahb_done_next;
      usbDone        <= usb_done_next;
      sizeError      <= err_next;
      bufferReserved <= reserved_next;
    end
  end

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed self-checking bench for buffer_arbiter.
module tb_buffer_arbiter;

  logic       clk;
  logic       rst;
  logic       ahbReq, ahbWrite, usbReq, usbWrite, flush;
  logic [1:0] dataSize;
  logic       bufWe, bufRe, ahbGrant, usbGrant, ahbDone, usbDone;
  logic       bufferReserved, sizeError;
  logic [5:0] wrPtr, rdPtr;
  logic [6:0] occupancy;

  int checks = 0;
  int errors = 0;

  buffer_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .ahbReq         (ahbReq),
    .ahbWrite       (ahbWrite),
    .dataSize       (dataSize),
    .usbReq         (usbReq),
    .usbWrite       (usbWrite),
    .flush          (flush),
    .bufWe          (bufWe),
    .bufRe          (bufRe),
    .wrPtr          (wrPtr),
    .rdPtr          (rdPtr),
    .ahbGrant       (ahbGrant),
    .usbGrant       (usbGrant),
    .ahbDone        (ahbDone),
    .usbDone        (usbDone),
    .occupancy      (occupancy),
    .bufferReserved (bufferReserved),
    .sizeError      (sizeError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Legal AHB transfer, entered and left at a negedge in IDLE.
  task automatic do_ahb(input logic wr, input logic [1:0] size);
    int len;
    len = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    ahbReq = 1'b1; ahbWrite = wr; dataSize = size;
    for (int i = 0; i < len; i++) @(negedge clk);
    ahbReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_usb(input logic wr);
    usbReq = 1'b1; usbWrite = wr;
    @(negedge clk);
    usbReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ahbReq = 0; ahbWrite = 0; dataSize = 0; usbReq = 0; usbWrite = 0; flush = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bufWe, bufRe, wrPtr, rdPtr, occupancy, ahbGrant, usbGrant, ahbDone, usbDone,
         bufferReserved, sizeError} !== 27'd0) begin
      errors++; $display("FAIL reset_outputs: we=%b re=%b wr=%0d rd=%0d occ=%0d, want all 0",
                         bufWe, bufRe, wrPtr, rdPtr, occupancy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bufWe, bufRe, wrPtr, rdPtr, occupancy, ahbGrant, usbGrant, ahbDone, usbDone,
         bufferReserved, sizeError} !== 27'd0) begin
      errors++; $display("FAIL post_reset_idle: outputs not all 0 (occ=%0d)", occupancy);
    end
  endtask

  task automatic test_ahb_write4();
    ahbReq = 1'b1; ahbWrite = 1'b1; dataSize = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bufWe, bufRe, ahbGrant, ahbDone, bufferReserved, wrPtr} !==
          {1'b1, 1'b0, 1'b1, (i == 3), 1'b1, 6'(i)}) begin
        errors++; $display("FAIL ahb_write4_cycle%0d: we=%b re=%b gnt=%b done=%b rsv=%b wr=%0d, want 1 0 1 %0d 1 %0d",
                           i, bufWe, bufRe, ahbGrant, ahbDone, bufferReserved, wrPtr, (i == 3), i);
      end
    end
    ahbReq = 1'b0;
    @(negedge clk);
    checks++;
    if ({bufWe, ahbGrant, ahbDone, wrPtr, occupancy, bufferReserved} !== {3'b000, 6'd4, 7'd4, 1'b1}) begin
      errors++; $display("FAIL ahb_write4_end: we=%b gnt=%b done=%b wr=%0d occ=%0d rsv=%b, want 0 0 0 4 4 1",
                         bufWe, ahbGrant, ahbDone, wrPtr, occupancy, bufferReserved);
    end
  endtask

  task automatic test_priority();
    logic exp_ahb;
    // Tie with occupancy 4: USB first under both policies (AHB was granted last).
    usbReq = 1; usbWrite = 0; ahbReq = 1; ahbWrite = 0; dataSize = 2'b01;
    @(negedge clk);
    checks++;
    if ({usbGrant, usbDone, bufRe, ahbGrant, rdPtr} !== {4'b1110, 6'd0}) begin
      errors++; $display("FAIL tie1_usb_first: ugnt=%b udone=%b re=%b agnt=%b rd=%0d, want 1 1 1 0 0",
                         usbGrant, usbDone, bufRe, ahbGrant, rdPtr);
    end
    usbReq = 0;
    @(negedge clk);
    checks++;
    if ({rdPtr, occupancy, bufRe} !== {6'd1, 7'd3, 1'b0}) begin
      errors++; $display("FAIL tie1_after_usb: rd=%0d occ=%0d re=%b, want 1 3 0", rdPtr, occupancy, bufRe);
    end
    @(negedge clk);
    checks++;
    if ({ahbGrant, bufRe, ahbDone, rdPtr} !== {3'b110, 6'd1}) begin
      errors++; $display("FAIL tie1_ahb_byte0: gnt=%b re=%b done=%b rd=%0d, want 1 1 0 1",
                         ahbGrant, bufRe, ahbDone, rdPtr);
    end
    @(negedge clk);
    checks++;
    if ({ahbGrant, bufRe, ahbDone, rdPtr} !== {3'b111, 6'd2}) begin
      errors++; $display("FAIL tie1_ahb_byte1: gnt=%b re=%b done=%b rd=%0d, want 1 1 1 2",
                         ahbGrant, bufRe, ahbDone, rdPtr);
    end
    ahbReq = 0;
    @(negedge clk);
    checks++;
    if ({rdPtr, occupancy} !== {6'd3, 7'd1}) begin
      errors++; $display("FAIL tie1_end: rd=%0d occ=%0d, want 3 1", rdPtr, occupancy);
    end
    do_usb(1'b1);
    // Tie right after a USB grant: fixed priority keeps USB, round robin picks AHB.
`ifdef BUFFER_ARB_ROUND_ROBIN_EN
    exp_ahb = 1'b1;
`else
    exp_ahb = 1'b0;
`endif
    usbReq = 1; usbWrite = 0; ahbReq = 1; ahbWrite = 0; dataSize = 2'b00;
    @(negedge clk);
    checks++;
    if ({ahbGrant, usbGrant, bufRe} !== {exp_ahb, !exp_ahb, 1'b1}) begin
      errors++; $display("FAIL tie2_winner: agnt=%b ugnt=%b re=%b, want %b %b 1",
                         ahbGrant, usbGrant, bufRe, exp_ahb, !exp_ahb);
    end
    if (exp_ahb) ahbReq = 0; else usbReq = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ahbGrant, usbGrant, bufRe} !== {!exp_ahb, exp_ahb, 1'b1}) begin
      errors++; $display("FAIL tie2_loser_served: agnt=%b ugnt=%b re=%b, want %b %b 1",
                         ahbGrant, usbGrant, bufRe, !exp_ahb, exp_ahb);
    end
    ahbReq = 0; usbReq = 0;
    @(negedge clk);
    checks++;
    if ({rdPtr, wrPtr, occupancy, bufferReserved} !== {6'd5, 6'd5, 7'd0, 1'b0}) begin
      errors++; $display("FAIL tie2_end: rd=%0d wr=%0d occ=%0d rsv=%b, want 5 5 0 0",
                         rdPtr, wrPtr, occupancy, bufferReserved);
    end
  endtask

  task automatic test_errors();
    // Read from empty buffer, then illegal size, then USB read from empty buffer.
    for (int k = 0; k < 2; k++) begin
      ahbReq = 1; ahbWrite = (k == 1); dataSize = (k == 0) ? 2'b00 : 2'b11;
      @(negedge clk);
      checks++;
      if ({sizeError, ahbDone, ahbGrant, bufWe, bufRe} !== 5'b11000) begin
        errors++; $display("FAIL ahb_err%0d: err=%b done=%b gnt=%b we=%b re=%b, want 1 1 0 0 0",
                           k, sizeError, ahbDone, ahbGrant, bufWe, bufRe);
      end
      ahbReq = 0;
      @(negedge clk);
      checks++;
      if ({sizeError, ahbDone, occupancy, rdPtr, wrPtr} !== {2'b00, 7'd0, 6'd5, 6'd5}) begin
        errors++; $display("FAIL ahb_err%0d_after: err=%b done=%b occ=%0d rd=%0d wr=%0d, want 0 0 0 5 5",
                           k, sizeError, ahbDone, occupancy, rdPtr, wrPtr);
      end
    end
    usbReq = 1; usbWrite = 0;
    @(negedge clk);
    checks++;
    if ({sizeError, usbDone, usbGrant, bufRe} !== 4'b1100) begin
      errors++; $display("FAIL usb_read_empty: err=%b done=%b gnt=%b re=%b, want 1 1 0 0",
                         sizeError, usbDone, usbGrant, bufRe);
    end
    usbReq = 0;
    @(negedge clk);
  endtask

  task automatic test_full();
    do_flush();
    for (int i = 0; i < 15; i++) do_ahb(1'b1, 2'b10);
    do_ahb(1'b1, 2'b01);
    do_ahb(1'b1, 2'b00);
    checks++;
    if (occupancy !== 7'd63) begin
      errors++; $display("FAIL fill_63: occ=%0d, want 63", occupancy);
    end
    ahbReq = 1; ahbWrite = 1; dataSize = 2'b01;
    @(negedge clk);
    checks++;
    if ({sizeError, ahbDone, bufWe, occupancy} !== {3'b110, 7'd63}) begin
      errors++; $display("FAIL overflow_err: err=%b done=%b we=%b occ=%0d, want 1 1 0 63",
                         sizeError, ahbDone, bufWe, occupancy);
    end
    ahbReq = 0;
    @(negedge clk);
    checks++;
    if ({sizeError, occupancy} !== {1'b0, 7'd63}) begin
      errors++; $display("FAIL overflow_after: err=%b occ=%0d, want 0 63", sizeError, occupancy);
    end
    do_ahb(1'b1, 2'b00);
    checks++;
    if ({occupancy, wrPtr, bufferReserved} !== {7'd64, 6'd0, 1'b1}) begin
      errors++; $display("FAIL fill_64: occ=%0d wr=%0d rsv=%b, want 64 0 1", occupancy, wrPtr, bufferReserved);
    end
    usbReq = 1; usbWrite = 1;
    @(negedge clk);
    checks++;
    if ({sizeError, usbDone, bufWe} !== 3'b110) begin
      errors++; $display("FAIL usb_write_full: err=%b done=%b we=%b, want 1 1 0", sizeError, usbDone, bufWe);
    end
    usbReq = 0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_flush();
    for (int i = 0; i < 15; i++) do_ahb(1'b1, 2'b10);
    do_ahb(1'b1, 2'b01);
    for (int i = 0; i < 15; i++) do_ahb(1'b0, 2'b10);
    checks++;
    if ({wrPtr, rdPtr, occupancy} !== {6'd62, 6'd60, 7'd2}) begin
      errors++; $display("FAIL wrap_setup: wr=%0d rd=%0d occ=%0d, want 62 60 2", wrPtr, rdPtr, occupancy);
    end
    ahbReq = 1; ahbWrite = 1; dataSize = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bufWe, wrPtr} !== {1'b1, 6'((62 + i) % 64)}) begin
        errors++; $display("FAIL wrap_cycle%0d: we=%b wr=%0d, want 1 %0d", i, bufWe, wrPtr, (62 + i) % 64);
      end
    end
    ahbReq = 0;
    @(negedge clk);
    checks++;
    if ({wrPtr, occupancy} !== {6'd2, 7'd6}) begin
      errors++; $display("FAIL wrap_end: wr=%0d occ=%0d, want 2 6", wrPtr, occupancy);
    end
    do_flush();
    checks++;
    if ({wrPtr, rdPtr, occupancy, bufferReserved, bufWe, bufRe} !== 22'd0) begin
      errors++; $display("FAIL flush_clear: wr=%0d rd=%0d occ=%0d rsv=%b, want 0 0 0 0",
                         wrPtr, rdPtr, occupancy, bufferReserved);
    end
  endtask

  task automatic test_reset_mid();
    do_ahb(1'b1, 2'b01);
    ahbReq = 1; ahbWrite = 1; dataSize = 2'b10;
    repeat (2) @(negedge clk);
    rst = 1; ahbReq = 0;
    @(negedge clk);
    checks++;
    if ({bufWe, bufRe, wrPtr, rdPtr, occupancy, ahbGrant, usbGrant, ahbDone, usbDone,
         bufferReserved, sizeError} !== 27'd0) begin
      errors++; $display("FAIL reset_mid_xfer: we=%b wr=%0d occ=%0d done=%b, want all 0",
                         bufWe, wrPtr, occupancy, ahbDone);
    end
    rst = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({ahbDone, bufWe, ahbGrant, wrPtr, occupancy} !== 16'd0) begin
        errors++; $display("FAIL reset_mid_after: done=%b we=%b gnt=%b wr=%0d occ=%0d, want 0",
                           ahbDone, bufWe, ahbGrant, wrPtr, occupancy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ahb_write4();
    test_priority();
    test_errors();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
